rv64_decode_execute: RTL and testbench
======================================

Name: rv64_decode_execute

Overview:
- Single-cycle RV64I decode/execute slice for the npc core: instruction decoder, 32x64 register file, ALU, branch/next-PC logic and load/store formatting toward a data-memory port.
- Sits between the IFU (which supplies pc/inst and registers nextpc) and an external combinational data memory.
- Everything is combinational except the register-file write at posedge clk.

Parameters:
- XLEN, 64, datapath width (only 64 supported)
- NREGS, 32, architectural integer registers

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pc  in  64  address of current instruction
- inst  in  32  current instruction word
- mem_rdata  in  64  doubleword read at {mem_addr[63:3],3'b0}, combinational
- nextpc  out  64  next fetch address
- mem_ena  out  1  data access this cycle (load or store)
- mem_wen  out  8  byte write mask, lane i = byte i of the doubleword
- mem_addr  out  64  effective address rs1+imm
- mem_wdata  out  64  store data shifted into byte lanes
- ebreak  out  1  inst == 32'h00100073

Behaviour:
- Reset: on a posedge clk with rst=1, all 32 registers clear to 0 and no write occurs. Outputs are combinational and have no reset state.
- x0 reads 0 and is never written.
- Reads are asynchronous. A write occurs at posedge when the decoded instruction writes rd, rd!=0, and rst=0. Read-after-write inside one cycle returns the old value.
- Supported instructions:
  - LUI, AUIPC, JAL, JALR.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI/SRLI/SRAI with 6-bit shamt.
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM-32: ADDIW, SLLIW, SRLIW, SRAIW.
  - OP-32: ADDW, SUBW, SLLW, SRLW, SRAW.
  - EBREAK.
- Immediates: I, S, B, U and J formats, sign-extended to 64 bits.
- W-ops compute on the low 32 bits and sign-extend the result. 32-bit shifts use shamt[4:0]; 64-bit shifts use [5:0].
- Next PC:
  - JAL: pc+immJ.
  - JALR: (rs1+immI) & ~1.
  - Taken branch: pc+immB.
  - Otherwise: pc+4.
  - JAL/JALR write pc+4 to rd.
- Loads:
  - mem_ena=1, mem_wen=0.
  - Byte lane selected by mem_addr[2:0]; result sign- or zero-extended per funct3.
- Stores:
  - mem_ena=1.
  - mem_wen = size mask (0x01/0x03/0x0F/0xFF) << mem_addr[2:0].
  - mem_wdata = rs2 << (8*mem_addr[2:0]).
  - Accesses crossing an 8-byte boundary are unsupported: mask bits shifted past lane 7 are dropped, and there is no trap.
- Non-memory instructions: mem_ena=0, mem_wen=0, mem_addr = ALU result.
- Illegal or unsupported encodings (including ECALL, FENCE, CSR): no register write, no memory access, nextpc=pc+4.
- ebreak: asserted combinationally, with no register write.
- Write-back select: ALU result, load data, or pc+4.

Decomposition:
- Package rv64_pkg holds:
  - opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP_IMM 0010011, OP 0110011, OP_IMM32 0011011, OP32 0111011, SYSTEM 1110011);
  - an alu_op_e enum (ADD, SUB, SLL, SRL, SRA, SLT, SLTU, XOR, OR, AND, COPY_B);
  - a wb_sel_e enum.
- One sub-module, rv64_regfile (2 read ports, 1 write port, sync reset); the ALU and decoder stay inline.

Test Plan:
- Reset: rst=1 for one cycle, then run `add x3,x1,x2` → x3=0, nextpc=pc+4.
- Arithmetic:
  - `addi x1,x0,-1` then `srli x2,x1,60` → x2=0xF.
  - `addiw x3,x0,0x7FF` then `slliw x4,x3,21` → x4=0xFFFFFFFF_FFE00000.
- Branch and jump (pc=0x80000000):
  - `beq x0,x0,-8` → nextpc=0x7FFFFFF8.
  - `bne x0,x0,8` → nextpc=0x80000004.
  - `jal x1,16` → nextpc=0x80000010, x1=0x80000004.
  - `jalr x0,1(x1)` with x1=0x100 → nextpc=0x100.
- Store/load (x5=0x1000, x6=0x11223344_55667788):
  - `sh x6,6(x5)` → mem_addr=0x1006, mem_wen=0xC0, mem_wdata[63:48]=0x7788.
  - `lb x7,3(x5)` with mem_rdata=0x00000000_80000000 → x7=0xFFFFFFFF_FFFFFF80.
  - `lbu` of the same byte → x7=0x80.
- Write to x0: `addi x0,x0,5` → x0 still reads 0.
- Exceptional decodes:
  - inst=0x00100073 → ebreak=1, no write.
  - inst=0xFFFFFFFF → no write, mem_ena=0, nextpc=pc+4.

Source files
------------

// File: rtl/rv64_pkg.sv
// Shared definitions for the RV64I decode/execute slice.
//   - base opcode constants (inst[6:0])
//   - alu_op_e : operation selected by the decoder for the inline ALU
//   - wb_sel_e : source of the register-file write data
//   - sext32   : sign-extend a 32-bit value to 64 bits (W-op results)
package rv64_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SRL,
        ALU_SRA,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_COPY_B
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC4
    } wb_sel_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/rv64_decode_execute_if.sv
// Fetch/data-memory bus of the decode/execute slice.
//   pc, inst      : current instruction from the IFU
//   nextpc        : next fetch address back to the IFU
//   mem_*         : combinational data-memory port (rdata is the aligned
//                   doubleword containing mem_addr)
//   ebreak        : current instruction is EBREAK
// modport slave  : the decode/execute slice
// modport master : the IFU / memory side driving it
interface rv64_decode_execute_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] nextpc;
    logic            mem_ena;
    logic [7:0]      mem_wen;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            ebreak;

    modport slave (
        input  pc, inst, mem_rdata,
        output nextpc, mem_ena, mem_wen, mem_addr, mem_wdata, ebreak
    );

    modport master (
        output pc, inst, mem_rdata,
        input  nextpc, mem_ena, mem_wen, mem_addr, mem_wdata, ebreak
    );
endinterface

// File: rtl/rv64_regfile.sv
// Integer register file: 2 asynchronous read ports, 1 write port.
//   clk, rst         : clock, synchronous active-high reset (clears all regs)
//   raddr1/raddr2    : read addresses, rdata1/rdata2 read data (x0 reads 0)
//   we, waddr, wdata : write port, applied at posedge; writes to x0 dropped
// A read in the same cycle as a write to that register returns the old value.
module rv64_regfile #(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREGS)-1:0] raddr1,
    input  logic [$clog2(NREGS)-1:0] raddr2,
    output logic [XLEN-1:0]          rdata1,
    output logic [XLEN-1:0]          rdata2,
    input  logic                     we,
    input  logic [$clog2(NREGS)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

endmodule

// File: rtl/rv64_decode_execute.sv
// Single-cycle RV64I decode/execute slice.
//   clk, rst : clock and synchronous active-high reset (register file only)
//   bus      : slave side of rv64_decode_execute_if (pc/inst in, nextpc out,
//              combinational data-memory port, ebreak flag)
// Decoder, ALU, branch/next-PC and load/store formatting are combinational;
// the only state is the register file.
module rv64_decode_execute
    import rv64_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    rv64_decode_execute_if.slave  bus
);

    // ---------------- instruction fields ----------------
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;

    assign inst   = bus.inst;
    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
    assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // ---------------- register file ----------------
    logic [XLEN-1:0] rs1_val, rs2_val, wb_data;
    logic            reg_we;

    rv64_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (reg_we),
        .waddr  (rd),
        .wdata  (wb_data)
    );

    // ---------------- decoder ----------------
    alu_op_e         alu_op;
    logic [XLEN-1:0] alu_a, alu_b;
    logic            word_op;
    wb_sel_e         wb_sel;
    logic            is_load, is_store, is_branch, is_jal, is_jalr;

    always_comb begin
        alu_op    = ALU_ADD;
        alu_a     = rs1_val;
        alu_b     = imm_i;
        word_op   = 1'b0;
        wb_sel    = WB_ALU;
        reg_we    = 1'b0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;

        case (opcode)
            OPC_LUI: begin
                alu_op = ALU_COPY_B;
                alu_b  = imm_u;
                reg_we = 1'b1;
            end
            OPC_AUIPC: begin
                alu_a  = bus.pc;
                alu_b  = imm_u;
                reg_we = 1'b1;
            end
            OPC_JAL: begin
                // ALU forms the jump target; rd gets pc+4
                alu_a  = bus.pc;
                alu_b  = imm_j;
                is_jal = 1'b1;
                wb_sel = WB_PC4;
                reg_we = 1'b1;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    is_jalr = 1'b1;
                    wb_sel  = WB_PC4;
                    reg_we  = 1'b1;
                end
            end
            OPC_BRANCH: begin
                is_branch = (funct3 != 3'b010) && (funct3 != 3'b011);
            end
            OPC_LOAD: begin
                if (funct3 != 3'b111) begin
                    is_load = 1'b1;
                    wb_sel  = WB_MEM;
                    reg_we  = 1'b1;
                end
            end
            OPC_STORE: begin
                alu_b    = imm_s;
                is_store = !funct3[2];
            end
            OPC_OP_IMM: begin
                reg_we = 1'b1;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                    3'b001: begin
                        // 6-bit shamt lives in imm_i[5:0]; upper six bits must be 0
                        if (inst[31:26] == 6'b000000) alu_op = ALU_SLL;
                        else                          reg_we = 1'b0;
                    end
                    default: begin // 3'b101
                        if (inst[31:26] == 6'b000000)      alu_op = ALU_SRL;
                        else if (inst[31:26] == 6'b010000) alu_op = ALU_SRA;
                        else                               reg_we = 1'b0;
                    end
                endcase
            end
            OPC_OP: begin
                alu_b  = rs2_val;
                reg_we = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: alu_op = ALU_ADD;
                    {7'h20, 3'b000}: alu_op = ALU_SUB;
                    {7'h00, 3'b001}: alu_op = ALU_SLL;
                    {7'h00, 3'b010}: alu_op = ALU_SLT;
                    {7'h00, 3'b011}: alu_op = ALU_SLTU;
                    {7'h00, 3'b100}: alu_op = ALU_XOR;
                    {7'h00, 3'b101}: alu_op = ALU_SRL;
                    {7'h20, 3'b101}: alu_op = ALU_SRA;
                    {7'h00, 3'b110}: alu_op = ALU_OR;
                    {7'h00, 3'b111}: alu_op = ALU_AND;
                    default:         reg_we = 1'b0;
                endcase
            end
            OPC_OP_IMM32: begin
                word_op = 1'b1;
                reg_we  = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b001}: alu_op = ALU_SLL;
                    {7'h00, 3'b101}: alu_op = ALU_SRL;
                    {7'h20, 3'b101}: alu_op = ALU_SRA;
                    default: begin
                        // ADDIW takes any immediate; everything else is illegal
                        if (funct3 == 3'b000) alu_op = ALU_ADD;
                        else                  reg_we = 1'b0;
                    end
                endcase
            end
            OPC_OP32: begin
                alu_b   = rs2_val;
                word_op = 1'b1;
                reg_we  = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: alu_op = ALU_ADD;
                    {7'h20, 3'b000}: alu_op = ALU_SUB;
                    {7'h00, 3'b001}: alu_op = ALU_SLL;
                    {7'h00, 3'b101}: alu_op = ALU_SRL;
                    {7'h20, 3'b101}: alu_op = ALU_SRA;
                    default:         reg_we = 1'b0;
                endcase
            end
            default: ; // SYSTEM, FENCE and unknown opcodes: no side effects
        endcase
    end

    assign bus.ebreak = (inst == INST_EBREAK);

    // ---------------- ALU ----------------
    logic [5:0]      shamt;
    logic [XLEN-1:0] srl_src, sra_src, alu_raw, alu_res;

    // W-op right shifts operate on the low word, zero- or sign-extended first,
    // so the low 32 bits of the 64-bit shift are the correct 32-bit result.
    assign shamt   = word_op ? {1'b0, alu_b[4:0]} : alu_b[5:0];
    assign srl_src = word_op ? {32'b0, alu_a[31:0]} : alu_a;
    assign sra_src = word_op ? sext32(alu_a[31:0])  : alu_a;

    always_comb begin
        alu_raw = '0;
        case (alu_op)
            ALU_ADD:    alu_raw = alu_a + alu_b;
            ALU_SUB:    alu_raw = alu_a - alu_b;
            ALU_SLL:    alu_raw = alu_a << shamt;
            ALU_SRL:    alu_raw = srl_src >> shamt;
            ALU_SRA:    alu_raw = $signed(sra_src) >>> shamt;
            ALU_SLT:    alu_raw = {{(XLEN-1){1'b0}}, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:   alu_raw = {{(XLEN-1){1'b0}}, alu_a < alu_b};
            ALU_XOR:    alu_raw = alu_a ^ alu_b;
            ALU_OR:     alu_raw = alu_a | alu_b;
            ALU_AND:    alu_raw = alu_a & alu_b;
            ALU_COPY_B: alu_raw = alu_b;
            default:    alu_raw = '0;
        endcase
    end

    assign alu_res = word_op ? sext32(alu_raw[31:0]) : alu_raw;

    // ---------------- branch / next PC ----------------
    logic            br_eq, br_lt, br_ltu, br_taken;
    logic [XLEN-1:0] pc_plus4;

    assign br_eq  = (rs1_val == rs2_val);
    assign br_lt  = ($signed(rs1_val) < $signed(rs2_val));
    assign br_ltu = (rs1_val < rs2_val);

    always_comb begin
        case (funct3)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = !br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = !br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_plus4 = bus.pc + 64'd4;

    always_comb begin
        if (is_jal)                     bus.nextpc = alu_res;
        else if (is_jalr)               bus.nextpc = alu_res & ~64'd1;
        else if (is_branch && br_taken) bus.nextpc = bus.pc + imm_b;
        else                            bus.nextpc = pc_plus4;
    end

    // ---------------- load / store formatting ----------------
    logic [2:0]      byte_off;
    logic [7:0]      size_mask;
    logic [XLEN-1:0] ld_shift, ld_data;

    assign byte_off = alu_res[2:0];

    always_comb begin
        case (funct3[1:0])
            2'b00:   size_mask = 8'h01;
            2'b01:   size_mask = 8'h03;
            2'b10:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Lanes shifted past byte 7 fall off: boundary-crossing accesses are
    // silently truncated rather than trapped.
    assign bus.mem_ena   = is_load || is_store;
    assign bus.mem_wen   = is_store ? (size_mask << byte_off) : 8'h00;
    assign bus.mem_addr  = alu_res;
    assign bus.mem_wdata = rs2_val << {byte_off, 3'b000};

    assign ld_shift = bus.mem_rdata >> {byte_off, 3'b000};

    always_comb begin
        case (funct3)
            3'b000:  ld_data = {{(XLEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b010:  ld_data = sext32(ld_shift[31:0]);
            3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
            3'b110:  ld_data = {32'b0, ld_shift[31:0]};
            default: ld_data = ld_shift;
        endcase
    end

    // ---------------- write-back select ----------------
    always_comb begin
        case (wb_sel)
            WB_MEM:  wb_data = ld_data;
            WB_PC4:  wb_data = pc_plus4;
            default: wb_data = alu_res;
        endcase
    end

endmodule

// File: tb/tb_rv64_decode_execute.sv
module tb_rv64_decode_execute;
    import rv64_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv64_decode_execute_if bus ();

    rv64_decode_execute #(.XLEN(64), .NREGS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [63:0] npc;
        logic        ena;
        logic [7:0]  wen;
        logic        ebrk;
        logic [63:0] addr;
        logic [63:0] wdata;
        bit          chk_addr;
        bit          chk_wdata;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] xr [32];
    logic [63:0] cur_pc;
    logic [2:0]  br_f3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {f7, r2, r1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[11:5], r2, r1, f3, imm[4:0], OPC_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3);
        return {imm[12], imm[10:5], r2, r1, f3, imm[4:1], imm[11], OPC_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
    endfunction

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // ---------------- reference model ----------------
    // Architectural effect of one instruction: expected port values plus the
    // register update, computed straight from the ISA rules.
    task automatic model(input logic [31:0] ins, input logic [63:0] pc,
                         input logic [63:0] rdat, output exp_t e);
        logic [63:0] a, b, ii, is, ib, iu, ij, v, ad, lsh;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [5:0]  sh;
        logic [31:0] t32;
        logic signed [63:0] sa;
        logic signed [31:0] sw;
        logic [15:0] m;
        logic        wr, taken;
        int          off;

        op = ins[6:0]; rd = ins[11:7]; f3 = ins[14:12]; f7 = ins[31:25];
        a  = xr[ins[19:15]];
        b  = xr[ins[24:20]];
        ii = 64'($signed(ins[31:20]));
        is = 64'($signed({ins[31:25], ins[11:7]}));
        ib = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        iu = 64'($signed({ins[31:12], 12'b0}));
        ij = 64'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));

        e.name = "";
        e.npc = pc + 64'd4; e.ena = 1'b0; e.wen = 8'h00; e.ebrk = 1'b0;
        e.addr = '0; e.wdata = '0; e.chk_addr = 1'b0; e.chk_wdata = 1'b0;
        wr = 1'b0; v = '0;

        case (op)
            OPC_LUI:   begin v = iu;      wr = 1'b1; e.chk_addr = 1'b1; e.addr = v; end
            OPC_AUIPC: begin v = pc + iu; wr = 1'b1; e.chk_addr = 1'b1; e.addr = v; end
            OPC_JAL:   begin e.npc = pc + ij; v = pc + 64'd4; wr = 1'b1; end
            OPC_JALR: if (f3 == 3'd0) begin
                e.npc = (a + ii) & ~64'd1; v = pc + 64'd4; wr = 1'b1;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'd0: taken = (a == b);
                    3'd1: taken = (a != b);
                    3'd4: taken = ($signed(a) <  $signed(b));
                    3'd5: taken = ($signed(a) >= $signed(b));
                    3'd6: taken = (a <  b);
                    3'd7: taken = (a >= b);
                    default: taken = 1'b0;
                endcase
                if (taken) e.npc = pc + ib;
            end
            OPC_LOAD: if (f3 != 3'd7) begin
                ad = a + ii; off = int'(ad[2:0]);
                e.ena = 1'b1; e.addr = ad; e.chk_addr = 1'b1;
                lsh = rdat >> (8 * off);
                case (f3)
                    3'd0: v = 64'($signed(lsh[7:0]));
                    3'd1: v = 64'($signed(lsh[15:0]));
                    3'd2: v = sx32(lsh[31:0]);
                    3'd3: v = lsh;
                    3'd4: v = {56'b0, lsh[7:0]};
                    3'd5: v = {48'b0, lsh[15:0]};
                    default: v = {32'b0, lsh[31:0]};
                endcase
                wr = 1'b1;
            end
            OPC_STORE: if (!f3[2]) begin
                ad = a + is; off = int'(ad[2:0]);
                e.ena = 1'b1; e.addr = ad; e.chk_addr = 1'b1;
                case (f3[1:0])
                    2'd0: m = 16'h0001;
                    2'd1: m = 16'h0003;
                    2'd2: m = 16'h000F;
                    default: m = 16'h00FF;
                endcase
                m = m << off;
                e.wen = m[7:0];
                e.wdata = b << (8 * off); e.chk_wdata = 1'b1;
            end
            OPC_OP_IMM: begin
                wr = 1'b1; sh = ins[25:20];
                case (f3)
                    3'd0: v = a + ii;
                    3'd2: v = {63'b0, $signed(a) < $signed(ii)};
                    3'd3: v = {63'b0, a < ii};
                    3'd4: v = a ^ ii;
                    3'd6: v = a | ii;
                    3'd7: v = a & ii;
                    3'd1: if (ins[31:26] == 6'h00) v = a << sh; else wr = 1'b0;
                    default: begin
                        sa = a;
                        if (ins[31:26] == 6'h00)      v = a >> sh;
                        else if (ins[31:26] == 6'h10) v = sa >>> sh;
                        else                          wr = 1'b0;
                    end
                endcase
                e.chk_addr = wr; e.addr = v;
            end
            OPC_OP: begin
                wr = 1'b1; sh = b[5:0]; sa = a;
                case ({f7, f3})
                    {7'h00, 3'd0}: v = a + b;
                    {7'h20, 3'd0}: v = a - b;
                    {7'h00, 3'd1}: v = a << sh;
                    {7'h00, 3'd2}: v = {63'b0, $signed(a) < $signed(b)};
                    {7'h00, 3'd3}: v = {63'b0, a < b};
                    {7'h00, 3'd4}: v = a ^ b;
                    {7'h00, 3'd5}: v = a >> sh;
                    {7'h20, 3'd5}: v = sa >>> sh;
                    {7'h00, 3'd6}: v = a | b;
                    {7'h00, 3'd7}: v = a & b;
                    default: wr = 1'b0;
                endcase
                e.chk_addr = wr; e.addr = v;
            end
            OPC_OP_IMM32, OPC_OP32: begin
                // shift amount: imm[4:0] for OP-IMM-32, rs2[4:0] for OP-32
                sh = (op == OPC_OP32) ? {1'b0, b[4:0]} : {1'b0, ins[24:20]};
                sw = a[31:0];
                wr = 1'b1;
                if (op == OPC_OP_IMM32 && f3 == 3'd0) begin
                    t32 = a[31:0] + ii[31:0]; v = sx32(t32);
                end else begin
                    case ({f7, f3})
                        {7'h00, 3'd0}: begin t32 = a[31:0] + b[31:0]; v = sx32(t32); wr = (op == OPC_OP32); end
                        {7'h20, 3'd0}: begin t32 = a[31:0] - b[31:0]; v = sx32(t32); wr = (op == OPC_OP32); end
                        {7'h00, 3'd1}: begin t32 = a[31:0] << sh; v = sx32(t32); end
                        {7'h00, 3'd5}: begin t32 = a[31:0] >> sh; v = sx32(t32); end
                        {7'h20, 3'd5}: begin t32 = sw >>> sh;     v = sx32(t32); end
                        default: wr = 1'b0;
                    endcase
                end
                e.chk_addr = wr; e.addr = v;
            end
            OPC_SYSTEM: e.ebrk = (ins == 32'h0010_0073);
            default: ;
        endcase

        if (wr && rd != 5'd0) xr[rd] = v;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input string nm, input logic [31:0] ins,
                         input logic [63:0] rdat, output exp_t e);
        @(posedge clk); #1;
        bus.pc = cur_pc; bus.inst = ins; bus.mem_rdata = rdat;
        model(ins, cur_pc, rdat, e);
        e.name = nm;
        cur_pc = e.npc;
    endtask

    task automatic run(input string nm, input logic [31:0] ins);
        exp_t e;
        drive(nm, ins, {$urandom, $urandom}, e);
        sb.push_back(e);
    endtask

    task automatic run_npc(input string nm, input logic [31:0] ins, input logic [63:0] npc);
        exp_t e;
        drive(nm, ins, {$urandom, $urandom}, e);
        e.npc = npc;
        sb.push_back(e);
    endtask

    // add x0, xN, x0 : no write, mem_addr shows xN
    task automatic probe(input string nm, input logic [4:0] r, input logic [63:0] val);
        exp_t e;
        drive(nm, enc_r(7'h00, 5'd0, r, 3'd0, 5'd0, OPC_OP), {$urandom, $urandom}, e);
        e.chk_addr = 1'b1; e.addr = val;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        bus.inst = enc_i(12'd5, 5'd0, 3'd0, 5'd1, OPC_OP_IMM); // must not land
        @(posedge clk); #1;
        rst = 1'b0;
        bus.inst = NOP;
        for (int i = 0; i < 32; i++) xr[i] = '0;
    endtask

    task automatic rand_inst(output logic [31:0] ins);
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] imm;
        logic [12:0] bimm;
        logic [20:0] jimm;
        rd  = 5'($urandom_range(0, 7));
        r1  = 5'($urandom_range(0, 7));
        r2  = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        f3  = 3'($urandom);
        f7  = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        case ($urandom_range(0, 11))
            0: ins = {20'($urandom), rd, ($urandom_range(0, 1) == 1) ? OPC_LUI : OPC_AUIPC};
            1, 2: begin
                if (f3 == 3'd1) imm = {6'h00, 6'($urandom)};
                if (f3 == 3'd5) imm = {f7[5] ? 6'h10 : 6'h00, 6'($urandom)};
                ins = enc_i(imm, r1, f3, rd, OPC_OP_IMM);
            end
            3, 4: begin
                if (f3 != 3'd0 && f3 != 3'd5) f7 = 7'h00;
                ins = enc_r(f7, r2, r1, f3, rd, OPC_OP);
            end
            5: begin
                f3 = (f3[0]) ? 3'd1 : ((f3[1]) ? 3'd5 : 3'd0);
                if (f3 == 3'd1) f7 = 7'h00;
                if (f3 != 3'd0) imm = {f7, 5'($urandom)};
                ins = enc_i(imm, r1, f3, rd, OPC_OP_IMM32);
            end
            6: begin
                f3 = (f3[0]) ? 3'd1 : ((f3[1]) ? 3'd5 : 3'd0);
                if (f3 == 3'd1) f7 = 7'h00;
                ins = enc_r(f7, r2, r1, f3, rd, OPC_OP32);
            end
            7: begin
                bimm = 13'($urandom) & 13'h1FFE;
                ins = enc_b(bimm, r2, r1, br_f3[$urandom_range(0, 5)]);
            end
            8: begin
                jimm = 21'($urandom) & 21'h1FFFFE;
                ins = enc_j(jimm, rd);
            end
            9:  ins = enc_i(imm, r1, 3'd0, rd, OPC_JALR);
            10: ins = enc_i(imm, r1, 3'($urandom_range(0, 6)), rd, OPC_LOAD);
            default: ins = enc_s(imm, r2, r1, 3'($urandom_range(0, 3)));
        endcase
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic cmp(input string nm, input string what,
                       input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s %s: got %h expected %h", nm, what, act, req);
        end
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            me = sb.pop_front();
            cmp(me.name, "nextpc", bus.nextpc, me.npc);
            cmp(me.name, "mem_ena", {63'b0, bus.mem_ena}, {63'b0, me.ena});
            cmp(me.name, "mem_wen", {56'b0, bus.mem_wen}, {56'b0, me.wen});
            cmp(me.name, "ebreak", {63'b0, bus.ebreak}, {63'b0, me.ebrk});
            if (me.chk_addr)  cmp(me.name, "mem_addr", bus.mem_addr, me.addr);
            if (me.chk_wdata) cmp(me.name, "mem_wdata", bus.mem_wdata, me.wdata);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        logic [31:0] ri;
        bus.pc = '0; bus.inst = NOP; bus.mem_rdata = '0;
        cur_pc = 64'h8000_0000;
        for (int i = 0; i < 32; i++) xr[i] = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // reset state
        drive("add_after_reset", enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3, OPC_OP), 64'd0, e);
        e.npc = 64'h8000_0004; e.chk_addr = 1'b1; e.addr = 64'd0;
        sb.push_back(e);
        probe("x3_after_reset", 5'd3, 64'd0);

        // arithmetic
        run("addi_m1", enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, OPC_OP_IMM));
        run("srli60",  enc_i(12'd60, 5'd1, 3'd5, 5'd2, OPC_OP_IMM));
        probe("x2_srli", 5'd2, 64'h0000_0000_0000_000F);
        run("addiw",   enc_i(12'h7FF, 5'd0, 3'd0, 5'd3, OPC_OP_IMM32));
        run("slliw21", enc_i(12'd21, 5'd3, 3'd1, 5'd4, OPC_OP_IMM32));
        probe("x4_slliw", 5'd4, 64'hFFFF_FFFF_FFE0_0000);

        // branch and jump
        cur_pc = 64'h8000_0000;
        run_npc("beq_back", enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0), 64'h7FFF_FFF8);
        cur_pc = 64'h8000_0000;
        run_npc("bne_nt", enc_b(13'd8, 5'd0, 5'd0, 3'd1), 64'h8000_0004);
        cur_pc = 64'h8000_0000;
        run_npc("jal16", enc_j(21'd16, 5'd1), 64'h8000_0010);
        probe("x1_link", 5'd1, 64'h8000_0004);
        run("addi_x1", enc_i(12'h100, 5'd0, 3'd0, 5'd1, OPC_OP_IMM));
        run_npc("jalr", enc_i(12'd1, 5'd1, 3'd0, 5'd0, OPC_JALR), 64'h100);

        // store / load
        run("lui_x5", {20'h00001, 5'd5, OPC_LUI});
        run("lui_x6", {20'h11223, 5'd6, OPC_LUI});
        run("addi_x6", enc_i(12'h344, 5'd6, 3'd0, 5'd6, OPC_OP_IMM));
        run("slli_x6", enc_i(12'd32, 5'd6, 3'd1, 5'd6, OPC_OP_IMM));
        run("lui_x7", {20'h55667, 5'd7, OPC_LUI});
        run("addi_x7", enc_i(12'h788, 5'd7, 3'd0, 5'd7, OPC_OP_IMM));
        run("or_x6", enc_r(7'h00, 5'd7, 5'd6, 3'd6, 5'd6, OPC_OP));
        probe("x6_val", 5'd6, 64'h1122_3344_5566_7788);
        drive("sh", enc_s(12'd6, 5'd6, 5'd5, 3'd1), 64'd0, e);
        e.addr = 64'h1006; e.chk_addr = 1'b1; e.wen = 8'hC0; e.ena = 1'b1;
        e.wdata = 64'h7788_0000_0000_0000; e.chk_wdata = 1'b1;
        sb.push_back(e);
        drive("lb", enc_i(12'd3, 5'd5, 3'd0, 5'd7, OPC_LOAD), 64'h0000_0000_8000_0000, e);
        sb.push_back(e);
        probe("x7_lb", 5'd7, 64'hFFFF_FFFF_FFFF_FF80);
        drive("lbu", enc_i(12'd3, 5'd5, 3'd4, 5'd7, OPC_LOAD), 64'h0000_0000_8000_0000, e);
        sb.push_back(e);
        probe("x7_lbu", 5'd7, 64'h0000_0000_0000_0080);

        // x0 and exceptional decodes
        run("addi_x0", enc_i(12'd5, 5'd0, 3'd0, 5'd0, OPC_OP_IMM));
        probe("x0_zero", 5'd0, 64'd0);
        run("addi_x31", enc_i(12'd123, 5'd0, 3'd0, 5'd31, OPC_OP_IMM));
        drive("ebreak", 32'h0010_0073, 64'd0, e);
        e.ebrk = 1'b1;
        sb.push_back(e);
        run_npc("all_ones", 32'hFFFF_FFFF, cur_pc + 64'd4);
        probe("x31_after_ones", 5'd31, 64'd123);
        run("ecall", 32'h0000_0073);
        run("fence", 32'h0000_000F);
        run("mul_illegal", enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd31, OPC_OP));
        run("srai_bad", enc_i(12'hC05, 5'd1, 3'd5, 5'd31, OPC_OP_IMM));
        probe("x31_after_illegal", 5'd31, 64'd123);

        // randomized stream
        for (int n = 0; n < 800; n++) begin
            rand_inst(ri);
            run("rand", ri);
        end
        for (int r = 1; r < 8; r++) run("rand_probe", enc_r(7'h00, 5'd0, 5'(r), 3'd0, 5'd0, OPC_OP));

        // mid-run reset clears everything and blocks the pending write
        do_reset();
        for (int r = 1; r < 8; r++) probe("reset_clear", 5'(r), 64'd0);

        repeat (3) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
